// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the two-way write-through data cache.
// CACHE_STATS_EN (optional build macro) adds hit/miss counters to cache_controller.
package cache_pkg;

    localparam logic [31:0] DATA_BASE = 32'd1024;
    localparam int unsigned SET_COUNT = 32'd64;
    localparam int unsigned TAG_W     = 32'd10;
    localparam int unsigned INDEX_W   = 32'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/cache_array.sv
// Two-way tag/valid/data storage with combinational hit detection.
// Only valid bits are reset; tag and data contents are qualified by them.
module cache_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_index,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_word_sel,
    output logic               o_hit,
    output logic               o_hit_way,
    output logic [31:0]        o_rdata,
    input  logic               i_fill_en,
    input  logic               i_fill_way,
    input  logic [63:0]        i_fill_block,
    input  logic               i_word_en,
    input  logic               i_word_way,
    input  logic [31:0]        i_word_data
);

    logic [SET_COUNT-1:0] r_valid [2];
    logic [TAG_W-1:0]     r_tag   [2][SET_COUNT];
    logic [1:0][31:0]     r_data  [2][SET_COUNT];
    logic                 w_hit0;
    logic                 w_hit1;
    logic                 w_way;

    // Valid bits: cleared by reset, set only when a complete block is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_way][i_index] <= 1'b1;
        end
    end

    // Tag and data storage: whole-block fill or single-word store update.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_fill_way][i_index]  <= i_tag;
            r_data[i_fill_way][i_index] <= i_fill_block;
        end else if (i_word_en) begin
            r_data[i_word_way][i_index][i_word_sel] <= i_word_data;
        end
    end

    // Tag compare; way0 wins if both ways ever match.
    always_comb begin
        w_hit0    = r_valid[0][i_index] && (r_tag[0][i_index] == i_tag);
        w_hit1    = r_valid[1][i_index] && (r_tag[1][i_index] == i_tag);
        w_way     = w_hit0 ? 1'b0 : 1'b1;
        o_hit     = w_hit0 | w_hit1;
        o_hit_way = w_way;
        o_rdata   = r_data[w_way][i_index][i_word_sel];
    end

endmodule

// File: rtl/cache_controller.sv
// Blocking two-way cache between the MEM stage and an SRAM controller.
// Optional macro CACHE_STATS_EN adds hit_count / miss_count outputs.
module cache_controller
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_gap;
    logic                 w_gap_next;
    logic [31:0]          r_word0;
    logic                 w_word0_en;
    logic [SET_COUNT-1:0] r_lru;
    logic                 w_lru_en;
    logic                 w_lru_val;

    logic [16:0]          w_off;
    logic [INDEX_W-1:0]   w_index;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_word_sel;
    logic                 w_rd_req;
    logic                 w_wr_req;
    logic                 w_arr_hit;
    logic                 w_arr_way;
    logic [31:0]          w_arr_rdata;
    logic                 w_fill_en;
    logic                 w_word_en;

    // DATA_BASE has zero low bits, so subtracting on [18:2] alone gives no borrow error.
    assign w_off      = address[18:2] - DATA_BASE[18:2];
    assign w_word_sel = w_off[0];
    assign w_index    = w_off[INDEX_W:1];
    assign w_tag      = w_off[INDEX_W+TAG_W:INDEX_W+1];
    assign w_wr_req   = mem_w_en;
    assign w_rd_req   = mem_r_en & ~mem_w_en;

    cache_array u_array (
        .clk          (clk),
        .rst          (rst),
        .i_index      (w_index),
        .i_tag        (w_tag),
        .i_word_sel   (w_word_sel),
        .o_hit        (w_arr_hit),
        .o_hit_way    (w_arr_way),
        .o_rdata      (w_arr_rdata),
        .i_fill_en    (w_fill_en),
        .i_fill_way   (r_lru[w_index]),
        .i_fill_block ({sram_rdata, r_word0}),
        .i_word_en    (w_word_en),
        .i_word_way   (w_arr_way),
        .i_word_data  (wdata)
    );

    // State, FILL1 gap flag, captured word0 and per-set LRU bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gap   <= 1'b0;
            r_word0 <= 32'd0;
            r_lru   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
            if (w_word0_en) begin
                r_word0 <= sram_rdata;
            end
            if (w_lru_en) begin
                r_lru[w_index] <= w_lru_val;
            end
        end
    end

    // Next-state, handshake and array-update decode.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = 1'b0;
        w_word0_en   = 1'b0;
        w_lru_en     = 1'b0;
        w_lru_val    = 1'b0;
        w_fill_en    = 1'b0;
        w_word_en    = 1'b0;
        ready        = 1'b0;
        rdata        = 32'd0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = 32'd0;
        sram_wdata   = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_state_next = WRITE;
                end else if (w_rd_req) begin
                    if (w_arr_hit) begin
                        ready     = 1'b1;
                        rdata     = w_arr_rdata;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_arr_way;
                    end else begin
                        w_state_next = FILL0;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            FILL0: begin
                sram_rd_en   = 1'b1;
                sram_address = {address[31:3], 3'b000};
                if (sram_ready) begin
                    w_word0_en   = 1'b1;
                    w_gap_next   = 1'b1;
                    w_state_next = FILL1;
                end else begin
                    w_state_next = FILL0;
                end
            end
            FILL1: begin
                // The first FILL1 cycle is the mandatory idle gap after word0.
                if (r_gap) begin
                    w_state_next = FILL1;
                end else begin
                    sram_rd_en   = 1'b1;
                    sram_address = {address[31:3], 3'b100};
                    if (sram_ready) begin
                        w_fill_en    = 1'b1;
                        w_lru_en     = 1'b1;
                        w_lru_val    = ~r_lru[w_index];
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = FILL1;
                    end
                end
            end
            WRITE: begin
                sram_wr_en   = 1'b1;
                sram_address = address;
                sram_wdata   = wdata;
                if (sram_ready) begin
                    ready        = 1'b1;
                    w_state_next = IDLE;
                    if (w_arr_hit) begin
                        w_word_en = 1'b1;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_arr_way;
                    end else begin
                        w_word_en = 1'b0;
                    end
                end else begin
                    w_state_next = WRITE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        w_cnt_hit;
    logic        w_cnt_miss;

    assign w_cnt_hit  = (r_state == IDLE) && w_rd_req && w_arr_hit;
    assign w_cnt_miss = (r_state == IDLE) && w_rd_req && !w_arr_hit;

    // Free-running wrap-around read hit / miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_cnt_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_cnt_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized self-checking bench for cache_controller with a latency-randomized SRAM model.
// Builds with or without CACHE_STATS_EN.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'd0;
    logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
`ifdef CACHE_STATS_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing store (word addressed) and log of completed SRAM transfers.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic [31:0] mem_q [int unsigned];
    xfer_t       log_q [$];
    int          ncyc = 0;
    int          last_done = 0;
    bit          prev_done = 1'b0;
    bit          hold_ready = 1'b0;
    int          wait_cnt = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (!mem_q.exists(k)) mem_q[k] = $urandom;
        return mem_q[k];
    endfunction

    // SRAM responder: random 0..3 wait cycles, transfers complete at the following rising edge.
    always @(negedge clk) begin
        xfer_t x;
        ncyc++;
        if (rst) begin
            prev_done  = 1'b0;
            sram_ready = 1'b0;
            sram_rdata = 32'd0;
            wait_cnt   = 0;
        end else begin
            check_val("rdwr_excl", 32'(sram_rd_en & sram_wr_en), 32'd0);
            if (prev_done) check_val("gap_after_done", 32'(sram_rd_en | sram_wr_en), 32'd0);
            prev_done = 1'b0;
            if (sram_rd_en || sram_wr_en) begin
                if (wait_cnt == 0 && !hold_ready) begin
                    sram_ready = 1'b1;
                    x.wr   = sram_wr_en;
                    x.addr = sram_address;
                    if (sram_wr_en) begin
                        mem_q[sram_address >> 2] = sram_wdata;
                        x.data     = sram_wdata;
                        sram_rdata = $urandom;
                    end else begin
                        sram_rdata = mem_rd(sram_address);
                        x.data     = sram_rdata;
                    end
                    log_q.push_back(x);
                    last_done = ncyc;
                    prev_done = 1'b1;
                end else begin
                    sram_ready = 1'b0;
                    sram_rdata = $urandom;
                    if (wait_cnt > 0) wait_cnt--;
                end
            end else begin
                sram_ready = 1'b0;
                sram_rdata = $urandom;
                wait_cnt   = $urandom_range(0, 3);
            end
        end
    end

    // Reference model: which blocks are resident, and which way each set evicts next.
    bit          m_valid  [64][2];
    int unsigned m_tag    [64][2];
    int          m_victim [64];
    int unsigned exp_hits;
    int unsigned exp_misses;

    function automatic int unsigned set_of(input logic [31:0] a);
        return ((a - 32'd1024) / 8) % 64;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return ((a - 32'd1024) / 512) % 1024;
    endfunction

    function automatic int model_way(input logic [31:0] a);
        int unsigned s;
        s = set_of(a);
        if (m_valid[s][0] && m_tag[s][0] == tag_of(a)) return 0;
        if (m_valid[s][1] && m_tag[s][1] == tag_of(a)) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i][0] = 1'b0;
            m_valid[i][1] = 1'b0;
            m_victim[i]   = 0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output bit was_hit, output logic [31:0] data);
        int w;
        int n;
        bit got;
        int unsigned s;
        logic [31:0] base;
        w = model_way(a);
        s = set_of(a);
        base = a & 32'hFFFF_FFF8;
        log_q.delete();
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        address  = a;
        wdata    = $urandom;
        n = 0;
        got = 1'b0;
        was_hit = 1'b0;
        data = 32'd0;
        #1;
        while (!got && n < 200) begin
            if (ready) got = 1'b1;
            else begin
                @(negedge clk); #1;
                n++;
            end
        end
        if (!got) begin
            check_val("rd_timeout", 32'd0, 32'd1);
            mem_r_en = 1'b0;
            return;
        end
        data = rdata;
        was_hit = (n == 0);
        check_val("rd_hit", 32'(was_hit), 32'(w >= 0));
        check_val("rd_data", data, mem_rd(a));
        if (w < 0) check_val("rd_ready_after_fill", ncyc, last_done + 1);
        @(negedge clk); #1;
        mem_r_en = 1'b0;
        if (w >= 0) begin
            check_val("hit_no_sram", log_q.size(), 32'd0);
        end else begin
            check_val("fill_count", log_q.size(), 32'd2);
            if (log_q.size() == 2) begin
                check_val("fill0_addr", log_q[0].addr, base);
                check_val("fill1_addr", log_q[1].addr, base + 32'd4);
                check_val("fill_is_read", 32'(log_q[0].wr | log_q[1].wr), 32'd0);
            end
            w = m_victim[s];
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = tag_of(a);
            exp_misses++;
        end
        exp_hits++;
        m_victim[s] = 1 - w;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int w;
        int n;
        bit got;
        w = model_way(a);
        log_q.delete();
        mem_w_en = 1'b1;
        mem_r_en = 1'($urandom_range(0, 1));
        address  = a;
        wdata    = d;
        n = 0;
        got = 1'b0;
        #1;
        while (!got && n < 200) begin
            if (ready) got = 1'b1;
            else begin
                @(negedge clk); #1;
                n++;
            end
        end
        if (!got) begin
            check_val("wr_timeout", 32'd0, 32'd1);
            mem_w_en = 1'b0;
            mem_r_en = 1'b0;
            return;
        end
        check_val("wr_not_in_idle", 32'(n != 0), 32'd1);
        check_val("wr_ready_on_done", 32'(sram_wr_en & sram_ready), 32'd1);
        @(negedge clk); #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
        check_val("wr_count", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            check_val("wr_is_write", 32'(log_q[0].wr), 32'd1);
            check_val("wr_addr", log_q[0].addr, a);
            check_val("wr_data", log_q[0].data, d);
        end
        if (w >= 0) m_victim[set_of(a)] = 1 - w;
    endtask

    task automatic do_idle();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address  = $urandom;
        wdata    = $urandom;
        #1;
        check_val("idle_ready", 32'(ready), 32'd1);
        check_val("idle_rdata", rdata, 32'd0);
        check_val("idle_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'd0);
        check_val("idle_sram_addr", sram_address, 32'd0);
        check_val("idle_sram_wdata", sram_wdata, 32'd0);
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
               + ($urandom_range(0, 1) << 2);
    endfunction

    initial begin
        bit          h;
        logic [31:0] d;
        int          n;
        logic [31:0] a_rst;

        rst = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address = 32'd0;
        wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'd0);
        rst = 1'b0;
        do_idle();
`ifdef CACHE_STATS_EN
        check_val("rst_hit_count", hit_count, 32'd0);
        check_val("rst_miss_count", miss_count, 32'd0);
`endif

        // First read after reset misses, the neighbouring word then hits.
        do_read(32'h400, h, d);
        check_val("r400_first_miss", 32'(h), 32'd0);
        do_read(32'h404, h, d);
        check_val("r404_hit", 32'(h), 32'd1);
`ifdef CACHE_STATS_EN
        check_val("stats_hit_2", hit_count, 32'd2);
        check_val("stats_miss_1", miss_count, 32'd1);
`endif

        // Three tags in set 0: the third evicts 0x400's way.
        do_read(32'h600, h, d);
        check_val("r600_miss", 32'(h), 32'd0);
        do_read(32'h800, h, d);
        check_val("r800_miss", 32'(h), 32'd0);
        do_read(32'h400, h, d);
        check_val("r400_evicted", 32'(h), 32'd0);

        // Write-through hit updates the line; write miss does not allocate.
        do_write(32'h404, 32'hDEAD_BEEF);
        do_read(32'h404, h, d);
        check_val("wr_hit_then_hit", 32'(h), 32'd1);
        check_val("wr_hit_data", d, 32'hDEAD_BEEF);
        do_write(32'h1000, 32'h1234_5678);
        do_read(32'h1000, h, d);
        check_val("no_write_alloc", 32'(h), 32'd0);

        // Reset while FILL1 is requesting word1.
        a_rst = 32'h1010;
        log_q.delete();
        mem_r_en = 1'b1;
        address  = a_rst;
        n = 0;
        while (log_q.size() < 1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("rst_fill0_done", 32'(log_q.size() >= 1), 32'd1);
        hold_ready = 1'b1;
        @(negedge clk); #1;
        check_val("fill1_gap", 32'(sram_rd_en), 32'd0);
        @(negedge clk); #1;
        check_val("fill1_req", 32'(sram_rd_en), 32'd1);
        check_val("fill1_req_addr", sram_address, (a_rst & 32'hFFFF_FFF8) + 32'd4);
        rst = 1'b1;
        #1;
        check_val("rst_abort_now", 32'(sram_rd_en), 32'd0);
        @(negedge clk); #1;
        check_val("rst_abort_next", 32'(sram_rd_en), 32'd0);
        mem_r_en = 1'b0;
        rst = 1'b0;
        hold_ready = 1'b0;
        model_reset();
        do_idle();
        do_read(a_rst, h, d);
        check_val("rst_refill_miss", 32'(h), 32'd0);

        // Random mix of reads, writes and idle cycles.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 5) do_read(rand_addr(), h, d);
            else if (r < 8) do_write(rand_addr() | 32'($urandom_range(0, 3)), $urandom);
            else do_idle();
        end
`ifdef CACHE_STATS_EN
        check_val("final_hit_count", hit_count, exp_hits);
        check_val("final_miss_count", miss_count, exp_misses);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
